riscv_div_seq: RTL
==================

Name: riscv_div_seq

Overview:
- Multi-cycle sequencer plus shift-subtract datapath for the ALU_DIVU, ALU_DIV, ALU_REMU and ALU_REM operators in the EX stage.
- Accepts one operation over a valid/ready handshake and iterates one quotient bit per cycle.
- Applies RISC-V special-case results and sign correction, then holds the result until the consumer takes it.
- The ID/EX controller can kill an operation in flight.

Parameters:
- WIDTH, 32, operand and result width in bits (power of 2, at least 8).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- operator_i  in  6  ALU operator; only the four ALU_DIV* codes are accepted
- op_a_i  in  WIDTH  dividend
- op_b_i  in  WIDTH  divisor
- in_valid_i  in  1  operation request
- in_ready_o  out  1  sequencer can accept a request
- kill_i  in  1  flush; aborts any operation in flight
- result_o  out  WIDTH  quotient or remainder
- out_valid_o  out  1  result_o is valid
- out_ready_i  in  1  consumer accepts the result
- busy_o  out  1  sequencer is not IDLE

Behaviour:
- Reset values: state IDLE, in_ready_o=1, out_valid_o=0, busy_o=0, result_o=0.
- Reset mid-operation discards the operation and returns to IDLE on the next edge.
- Operator decode: operator_i[1] selects remainder, operator_i[0] selects signed. operator_i[5:2] must be 4'b1100.
- A request with any other operator produces no transfer; the state stays IDLE.
- Transfer: in_valid_i & in_ready_o & valid operator & !kill_i. kill_i wins over a simultaneous request.
- in_ready_o = (state==IDLE). busy_o = !in_ready_o.
- States:
  - IDLE: on transfer, latch the operator and operands; go to PREP.
  - PREP (1 cycle):
    - Signed ops: take |a| and |b|; record the quotient sign (sa^sb) and the remainder sign (sa).
    - Divide by zero: quotient = all ones, remainder = a; go to DONE.
    - Signed overflow (a = 2^(WIDTH-1), b = -1): quotient = a, remainder = 0; go to DONE.
    - Otherwise clear the partial remainder, set cnt = WIDTH-1, go to ITER.
  - ITER (WIDTH cycles):
    - Shift {rem, quot} left by one, shifting in the next dividend bit.
    - If rem >= |b|, subtract |b| and set quot[0]=1.
    - Leave for FIX after the cycle with cnt==0; cnt decrements, no wrap.
    - Compare and subtract use WIDTH+1 bits internally.
  - FIX (1 cycle): negate the quotient if its sign flag is set; negate the remainder if its sign flag is set and it is non-zero. Select per operator; go to DONE.
  - DONE: out_valid_o=1 and result_o stable. On out_ready_i go to IDLE.
- No new request is accepted in the same cycle as the out_ready_i handshake.
- Latency (transfer edge = E0):
  - Normal: PREP in cycle 1, ITER in cycles 2..WIDTH+1, FIX in cycle WIDTH+2, out_valid_o from cycle WIDTH+3 (35 for WIDTH=32).
  - Special cases: out_valid_o from cycle 2.
- kill_i in any state returns to IDLE on the next edge. out_valid_o drops in that cycle's successor and no result is delivered.
- kill_i in DONE with out_ready_i in the same cycle: the result counts as consumed.

Optional Feature:
- RISCV_DIV_EARLY_OUT_EN defined:
  - PREP computes lz = leading zeros of |a|.
  - The dividend is pre-shifted left by lz and cnt = WIDTH-1-lz.
  - |a|==0 skips ITER and goes straight to FIX (quotient 0, remainder 0).
  - Latency for a normal op becomes WIDTH-lz+3 cycles.
- Undefined: always WIDTH iterations; there is no lzc logic.

Decomposition:
- Shared package riscv_defines: the ALU_DIVU/DIV/REMU/REM codes (existing), plus new items:
  - DIV_STATE_WIDTH = 3.
  - Enum typedef div_state_t {DIV_IDLE, DIV_PREP, DIV_ITER, DIV_FIX, DIV_DONE}.
  - Parameter DIV_OPSEL_REM_BIT = 1.
  - Parameter DIV_OPSEL_SIGN_BIT = 0.
- Sub-module riscv_div_lzc:
  - Combinational WIDTH-bit leading-zero counter, output width $clog2(WIDTH)+1.
  - Instantiated only under RISCV_DIV_EARLY_OUT_EN.

Test Plan:
- DIVU a=100 b=7, out_ready_i=1 -> result 14, out_valid_o first high 35 cycles after the transfer; REMU with the same operands -> 2.
- DIV a=-100 b=7 -> 0xFFFFFFF2 (-14); REM a=-100 b=7 -> 0xFFFFFFFE (-2); REM a=100 b=-7 -> 2.
- DIVU a=5 b=0 -> 0xFFFFFFFF; REM a=5 b=0 -> 5; DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0. All special cases give out_valid_o at cycle 2.
- Backpressure and kill:
  - Hold out_ready_i=0 for 10 cycles in DONE -> result_o stable and in_ready_o=0 throughout.
  - Assert kill_i in ITER cycle 5 -> IDLE next cycle, no out_valid_o.
  - A new DIVU 9/3 then returns 3.
- Assert rst in ITER cycle 10 -> next cycle in_ready_o=1, out_valid_o=0; in_valid_i with operator ALU_ADD -> no transfer, busy_o stays 0.
- With RISCV_DIV_EARLY_OUT_EN: DIVU a=3 b=1 -> result 3 at cycle 5 (lz=30); DIVU a=0 b=9 -> result 0 at cycle 3.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared core definitions: ALU operator codes and the divider sequencer types.
// The divider decodes the low two operator bits as {rem, signed}.
package riscv_defines;

    localparam int unsigned ALU_OP_WIDTH = 6;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 6'b011000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 6'b110000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 6'b110001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU = 6'b110010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REM  = 6'b110011;

    localparam int unsigned DIV_STATE_WIDTH    = 3;
    localparam int unsigned DIV_OPSEL_REM_BIT  = 1;
    localparam int unsigned DIV_OPSEL_SIGN_BIT = 0;

    typedef enum logic [DIV_STATE_WIDTH-1:0] {
        DIV_IDLE,
        DIV_PREP,
        DIV_ITER,
        DIV_FIX,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/riscv_div_lzc.sv
// Combinational leading-zero counter.
//   data_i : WIDTH-bit input word
//   lz_o   : number of leading zeros, WIDTH when data_i is zero
// Only used by the divider when RISCV_DIV_EARLY_OUT_EN is defined.
module riscv_div_lzc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]       data_i,
    output logic [$clog2(WIDTH):0] lz_o
);

    localparam int unsigned LZ_W = $clog2(WIDTH) + 1;

    // Ascending scan: the highest set bit is the last one to assign.
    always_comb begin
        lz_o = LZ_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                lz_o = LZ_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/riscv_div_seq.sv
// Multi-cycle divider for ALU_DIVU/DIV/REMU/REM: one quotient bit per cycle
// (restoring shift-subtract), RISC-V special-case results, sign fix-up.
//   clk, rst                : clock, synchronous active-high reset
//   operator_i, op_a_i/op_b_i : operation request (dividend, divisor)
//   in_valid_i / in_ready_o  : request handshake
//   kill_i                   : flush, aborts any operation in flight
//   result_o, out_valid_o / out_ready_i : result handshake
//   busy_o                   : sequencer not idle
// Optional: define RISCV_DIV_EARLY_OUT_EN to skip the dividend's leading zeros.
module riscv_div_seq
    import riscv_defines::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ALU_OP_WIDTH-1:0] operator_i,
    input  logic [WIDTH-1:0]        op_a_i,
    input  logic [WIDTH-1:0]        op_b_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    kill_i,
    output logic [WIDTH-1:0]        result_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    busy_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic             op_rem_q, op_rem_d;
    logic             op_sign_q, op_sign_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    // quot_q holds the raw dividend until PREP, div_q the raw divisor.
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             op_valid, transfer;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             sub_ok;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    assign op_valid = (operator_i[ALU_OP_WIDTH-1:2] == 4'b1100);
    assign transfer = in_valid_i & (state_q == DIV_IDLE) & op_valid & ~kill_i;

    assign sign_a = op_sign_q & quot_q[WIDTH-1];
    assign sign_b = op_sign_q & div_q[WIDTH-1];
    assign abs_a  = sign_a ? -quot_q : quot_q;
    assign abs_b  = sign_b ? -div_q : div_q;

    // rem_q < divisor always, so the shifted value needs one extra bit to compare,
    // but the difference always fits back into WIDTH bits.
    assign rem_sh  = {rem_q, quot_q[WIDTH-1]};
    assign sub_ok  = (rem_sh >= {1'b0, div_q});
    assign rem_sub = rem_sh[WIDTH-1:0] - div_q;

    assign quot_fix = neg_quot_q ? -quot_q : quot_q;
    assign rem_fix  = (neg_rem_q && (rem_q != '0)) ? -rem_q : rem_q;

`ifdef RISCV_DIV_EARLY_OUT_EN
    logic [CNT_W:0] lz;

    riscv_div_lzc #(
        .WIDTH (WIDTH)
    ) u_lzc (
        .data_i (abs_a),
        .lz_o   (lz)
    );
`endif

    always_comb begin
        state_d    = state_q;
        op_rem_d   = op_rem_q;
        op_sign_d  = op_sign_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        quot_d     = quot_q;
        div_d      = div_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        result_d   = result_q;

        unique case (state_q)
            DIV_IDLE: begin
                if (transfer) begin
                    op_rem_d  = operator_i[DIV_OPSEL_REM_BIT];
                    op_sign_d = operator_i[DIV_OPSEL_SIGN_BIT];
                    quot_d    = op_a_i;
                    div_d     = op_b_i;
                    state_d   = DIV_PREP;
                end
            end
            DIV_PREP: begin
                neg_quot_d = sign_a ^ sign_b;
                neg_rem_d  = sign_a;
                div_d      = abs_b;
                if (div_q == '0) begin
                    result_d = op_rem_q ? quot_q : '1;
                    state_d  = DIV_DONE;
                end else if (op_sign_q && (quot_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&div_q)) begin
                    result_d = op_rem_q ? '0 : quot_q;
                    state_d  = DIV_DONE;
                end else begin
                    rem_d = '0;
`ifdef RISCV_DIV_EARLY_OUT_EN
                    if (abs_a == '0) begin
                        quot_d  = '0;
                        state_d = DIV_FIX;
                    end else begin
                        quot_d  = abs_a << lz;
                        cnt_d   = CNT_W'(WIDTH - 1) - lz[CNT_W-1:0];
                        state_d = DIV_ITER;
                    end
`else
                    quot_d  = abs_a;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    state_d = DIV_ITER;
`endif
                end
            end
            DIV_ITER: begin
                if (sub_ok) begin
                    rem_d  = rem_sub;
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = rem_sh[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = DIV_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV_FIX: begin
                result_d = op_rem_q ? rem_fix : quot_fix;
                state_d  = DIV_DONE;
            end
            DIV_DONE: begin
                if (out_ready_i) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase

        if (kill_i) begin
            state_d = DIV_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            op_rem_q   <= 1'b0;
            op_sign_q  <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            quot_q     <= '0;
            div_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_rem_q   <= op_rem_d;
            op_sign_q  <= op_sign_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            quot_q     <= quot_d;
            div_q      <= div_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
        end
    end

    assign in_ready_o  = (state_q == DIV_IDLE);
    assign busy_o      = ~in_ready_o;
    assign out_valid_o = (state_q == DIV_DONE);
    assign result_o    = result_q;

endmodule
